// File: rtl/shift_scheduler.sv
// Round-robin scheduler that serialises one of two parallel words, MSB first, into a downstream SIPO register.
// Optional even-parity trailer bit is built when SHIFT_SCHEDULER_PARITY_EN is defined.
module shift_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             cl,
  input  logic             r,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic             sclr,
  output logic             sen,
  output logic             sout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SHIFT_SCHEDULER_PARITY_EN
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, PAR, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DONE} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             ptr;
  logic [WIDTH-1:0] shadow;
  logic             pick1;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // ptr holds the last-served requester; on a tie the other one wins
  assign pick1 = req1 & (~req0 | ~ptr);

  always_ff @(posedge cl) begin
    if (r) state <= IDLE;
    else   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (req0 | req1) state_nxt = CLEAR;
      CLEAR: state_nxt = SHIFT;
      SHIFT: begin
        if (cnt == LAST) begin
`ifdef SHIFT_SCHEDULER_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SHIFT_SCHEDULER_PARITY_EN
      PAR:   state_nxt = DONE;
`endif
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shadow word rotates left so the current bit is always the MSB; after
  // WIDTH rotations it is back to the original, and parity is rotation-invariant.
  always_ff @(posedge cl) begin
    if (r) begin
      cnt    <= '0;
      ptr    <= 1'b1;
      shadow <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt0   <= ~pick1;
            gnt1   <= pick1;
            shadow <= pick1 ? din1 : din0;
          end
        end
        CLEAR: cnt <= '0;
        SHIFT: begin
          cnt    <= cnt + CW'(1);
          shadow <= {shadow[WIDTH-2:0], shadow[WIDTH-1]};
        end
        DONE: begin
          ptr  <= gnt1;
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sclr = (state == CLEAR);
    busy = (state != IDLE);
    ack0 = (state == DONE) & gnt0;
    ack1 = (state == DONE) & gnt1;
    sen  = 1'b0;
    sout = 1'b0;
    if (state == SHIFT) begin
      sen  = 1'b1;
      sout = shadow[WIDTH-1];
    end
`ifdef SHIFT_SCHEDULER_PARITY_EN
    if (state == PAR) begin
      sen  = 1'b1;
      sout = even_parity(shadow);
    end
`endif
  end

endmodule

// File: doc/shift_scheduler.md
# shift_scheduler

Sequencing and arbitration controller for the 8-bit serial-in/parallel-out shift register. Two requesters each offer a parallel word; the block grants one at a time (round-robin), clears the downstream register, and then feeds the granted word bit-serially, MSB first, with a shift-enable strobe. When the last bit has been shifted, the block acknowledges the requester.

## Interface
Parameters:
- WIDTH, 8, word length in bits; bit counter is $clog2(WIDTH+1) bits wide.

Ports:
- cl  input  1  clock; all state updates on rising edge.
- r  input  1  reset, synchronous, active-high.
- req0, req1  input  1 each  request; held high by requester until its ack pulse.
- din0, din1  input  WIDTH each  word to transmit; sampled only at grant.
- gnt0, gnt1  output  1 each  grant; one-hot or zero; high from grant through DONE.
- ack0, ack1  output  1 each  one-cycle pulse in DONE for the granted requester.
- sclr  output  1  clear strobe to the downstream register's `r`; high in CLEAR.
- sen  output  1  shift enable; high in each cycle that `sout` carries a valid bit.
- sout  output  1  serial data to the downstream `sin`; 0 when `sen`=0.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, SHIFT, PAR (macro only), DONE.
- IDLE: if any request is high, arbitrate, latch the winner's din into the shadow word, set its gnt, and go to CLEAR; otherwise stay.
- Arbitration is round-robin:
  - A single request wins.
  - If both requests are high, the requester not served last wins.
  - The last-served pointer resets to 1, so req0 wins the first tie after reset.
- CLEAR: sclr=1 for one cycle; go to SHIFT; counter=0.
- SHIFT: sen=1, sout=shadow[WIDTH-1-count], count++; after count reaches WIDTH-1, go to PAR if enabled, else DONE.
- PAR: sen=1, sout=XOR of the shadow bits (even parity); go to DONE.
- DONE: ack of the granted requester=1; update the last-served pointer; clear gnt at exit; go to IDLE.
- IDLE lasts at least one cycle between frames, so a held request re-arbitrates only after the ack.
- din changes after grant have no effect. Deasserting req mid-frame does not abort the frame; the ack is still issued.
- Reset values: state=IDLE, all outputs 0, counter=0, pointer=1, shadow=0.
- Reset mid-frame: on the next edge all outputs return to 0. No ack is issued, and the frame is discarded.
- Reset has priority over every transition.

## Timing
- Request high before edge E0 → after E0: gnt and busy high, sclr high (CLEAR).
- After E1: first data bit (MSB) on sout, sen=1.
- Data bit k is valid after edge E(1+k), for k=0..WIDTH-1.
- With the macro: parity bit after E(WIDTH+1); DONE after E(WIDTH+2).
- Without the macro: DONE after E(WIDTH+1).
- ack pulse: exactly one cycle, in DONE. gnt and busy drop after the following edge (IDLE).
- Frame length from grant to IDLE, inclusive of DONE: WIDTH+2 cycles without the macro, WIDTH+3 with it.
- Downstream register contents equal the transmitted word one edge after the last data bit when shifting only on sen=1. With parity, the register holds the data shifted once more, including the parity bit.
- Maximum throughput with one requester held high: one word per WIDTH+3 cycles (no macro) / WIDTH+4 cycles (macro), including the IDLE gap.
- All outputs are registered or decoded from registered state only; no combinational path from req/din to any output.

## Configuration
- SHIFT_SCHEDULER_PARITY_EN defined: the PAR state exists and one even-parity bit follows the data bits with sen=1.
- SHIFT_SCHEDULER_PARITY_EN undefined: no PAR state; SHIFT goes directly to DONE; frame is one cycle shorter.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0, busy=0.
- req0 only, din0=8'hA5, no macro:
  - gnt0=1 and sclr=1 for 1 cycle, then sout=1,0,1,0,0,1,0,1 with sen=1 for 8 cycles.
  - Then ack0 for 1 cycle; gnt0 falls one cycle later; total frame 10 cycles.
- Simultaneous req0/req1 held (din0=8'h0F, din1=8'hF0):
  - Grants alternate 0,1,0,1.
  - Each ack matches its gnt.
  - At least one IDLE cycle between frames.
- din0 changed from 8'h3C to 8'hFF one cycle after gnt0 → serial stream is still 0,0,1,1,1,1,0,0.
- r asserted during the 4th SHIFT cycle → after the next edge all outputs 0 and no ack. A following req1 gets its grant, and the pointer has been restored to its reset value.
- Macro defined, din1=8'h07 → 8 data bits, then sout=1 (parity of 3 ones) with sen=1, then ack1; frame 11 cycles.
